// File: rtl/core_pkg.sv
// Shared core definitions: canonical NOP and the fetch-to-decode entry format.
package core_pkg;

  localparam int unsigned CORE_XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [CORE_XLEN-1:0] instr;
    logic [CORE_XLEN-1:0] pc;
    logic [CORE_XLEN-1:0] pcplus4;
  } fetch_entry_t;

endpackage

// File: rtl/fq_mem.sv
// Register-array storage for fetch_queue: one synchronous write port, one async read port.
module fq_mem
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = $bits(fetch_entry_t),
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Contents are intentionally not reset; occupancy tracking makes stale data invisible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// In-order fetch-to-decode buffer with show-ahead head, flush, and NOP bubble when empty.
module fetch_queue
  import core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DEPTH         = 4,
  localparam int unsigned PTR_W        = $clog2(DEPTH),
  localparam int unsigned CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [DATA_WIDTH-1:0]    enq_instr,
  input  logic [ADDRESS_WIDTH-1:0] enq_pc,
  input  logic [DATA_WIDTH-1:0]    enq_pcplus4,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [DATA_WIDTH-1:0]    deq_instr,
  output logic [ADDRESS_WIDTH-1:0] deq_pc,
  output logic [DATA_WIDTH-1:0]    deq_pcplus4,
  output logic [CNT_W-1:0]         count
);

  localparam int unsigned ENTRY_W = 2 * DATA_WIDTH + ADDRESS_WIDTH;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic               enq_fire;
  logic               deq_fire;
  logic               mem_we;
  logic [ENTRY_W-1:0] mem_wdata;
  logic [ENTRY_W-1:0] mem_rdata;

  // Flags depend only on registered occupancy, so no input reaches an output combinationally.
  assign enq_ready = (count_q != CNT_W'(DEPTH));
  assign deq_valid = (count_q != '0);
  assign count     = count_q;

  assign enq_fire = enq_valid && enq_ready;
  assign deq_fire = deq_valid && deq_ready;

  // A flushed or reset cycle drops the presented entry, so it never touches storage.
  assign mem_we    = enq_fire && !flush && !rst;
  assign mem_wdata = {enq_instr, enq_pc, enq_pcplus4};

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (deq_fire) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (enq_fire && !deq_fire) begin
        count_d = count_q + CNT_W'(1);
      end else if (deq_fire && !enq_fire) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  fq_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (mem_wdata),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    deq_instr   = DATA_WIDTH'(NOP_INSTR);
    deq_pc      = '0;
    deq_pcplus4 = '0;
    if (deq_valid) begin
      {deq_instr, deq_pc, deq_pcplus4} = mem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: table-driven cycles plus scoreboard of queued entries.
module tb_fetch_queue;
  import core_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_instr;
  logic [31:0] enq_pc;
  logic [31:0] enq_pcplus4;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_instr;
  logic [31:0] deq_pc;
  logic [31:0] deq_pcplus4;
  logic [2:0]  count;

  fetch_queue #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (32),
    .DEPTH         (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .enq_instr   (enq_instr),
    .enq_pc      (enq_pc),
    .enq_pcplus4 (enq_pcplus4),
    .deq_valid   (deq_valid),
    .deq_ready   (deq_ready),
    .deq_instr   (deq_instr),
    .deq_pc      (deq_pc),
    .deq_pcplus4 (deq_pcplus4),
    .count       (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ev;
    logic [31:0] pc;
    logic        dr;
    int          exp_cnt;
    logic        exp_dv;
    logic        exp_er;
  } vec_t;

  fetch_entry_t sb_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return 32'h00500093 + (pc << 20);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, check state against scoreboard (and table if given), update model.
  task automatic cycle(input logic ev, input logic [31:0] pc, input logic dr, input logic fl,
                       input logic rs, input logic use_tbl, input int ecnt, input logic edv,
                       input logic eer);
    fetch_entry_t e;
    logic m_enq;
    logic m_deq;
    @(negedge clk);
    enq_valid   = ev;
    enq_pc      = pc;
    enq_instr   = mk_instr(pc);
    enq_pcplus4 = pc + 32'd4;
    deq_ready   = dr;
    flush       = fl;
    rst         = rs;
    #1;
    chk("count", 32'(count), 32'(sb_q.size()));
    chk("deq_valid", 32'(deq_valid), 32'(sb_q.size() != 0));
    chk("enq_ready", 32'(enq_ready), 32'(sb_q.size() != DEPTH));
    if (use_tbl) begin
      chk("tbl_count", 32'(count), 32'(ecnt));
      chk("tbl_deq_valid", 32'(deq_valid), 32'(edv));
      chk("tbl_enq_ready", 32'(enq_ready), 32'(eer));
    end
    if (sb_q.size() == 0) begin
      chk("nop_instr", deq_instr, NOP_INSTR);
      chk("nop_pc", deq_pc, 32'h0);
      chk("nop_pcplus4", deq_pcplus4, 32'h0);
    end else begin
      chk("head_instr", deq_instr, sb_q[0].instr);
      chk("head_pc", deq_pc, sb_q[0].pc);
      chk("head_pcplus4", deq_pcplus4, sb_q[0].pcplus4);
    end
    m_enq = ev && (sb_q.size() != DEPTH);
    m_deq = dr && (sb_q.size() != 0);
    if (rs || fl) begin
      sb_q.delete();
    end else begin
      if (m_deq) void'(sb_q.pop_front());
      if (m_enq) begin
        e.instr   = mk_instr(pc);
        e.pc      = pc;
        e.pcplus4 = pc + 32'd4;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic step(input logic ev, input logic [31:0] pc, input logic dr, input logic fl,
                      input logic rs);
    cycle(ev, pc, dr, fl, rs, 1'b0, 0, 1'b0, 1'b0);
  endtask

  vec_t vecs[$];

  function automatic vec_t v(input logic ev, input logic [31:0] pc, input logic dr,
                             input int c, input logic dv, input logic er);
    vec_t r;
    r.ev = ev; r.pc = pc; r.dr = dr; r.exp_cnt = c; r.exp_dv = dv; r.exp_er = er;
    return r;
  endfunction

  initial begin
    // Expected columns describe the state seen before each cycle's edge.
    vecs.push_back(v(0, 32'h00, 1, 0, 0, 1));  // reset idle
    vecs.push_back(v(1, 32'h00, 1, 0, 0, 1));  // pass-through
    vecs.push_back(v(0, 32'h00, 1, 1, 1, 1));
    vecs.push_back(v(0, 32'h00, 0, 0, 0, 1));
    vecs.push_back(v(1, 32'h00, 0, 0, 0, 1));  // fill stalled
    vecs.push_back(v(1, 32'h04, 0, 1, 1, 1));
    vecs.push_back(v(1, 32'h08, 0, 2, 1, 1));
    vecs.push_back(v(1, 32'h0C, 0, 3, 1, 1));
    vecs.push_back(v(1, 32'h10, 0, 4, 1, 0));  // fifth enq refused
    vecs.push_back(v(0, 32'h00, 1, 4, 1, 0));
    vecs.push_back(v(0, 32'h00, 1, 3, 1, 1));
    vecs.push_back(v(0, 32'h00, 1, 2, 1, 1));
    vecs.push_back(v(0, 32'h00, 1, 1, 1, 1));
    vecs.push_back(v(0, 32'h00, 0, 0, 0, 1));
    vecs.push_back(v(1, 32'h20, 0, 0, 0, 1));  // full with enq+deq
    vecs.push_back(v(1, 32'h24, 0, 1, 1, 1));
    vecs.push_back(v(1, 32'h28, 0, 2, 1, 1));
    vecs.push_back(v(1, 32'h2C, 0, 3, 1, 1));
    vecs.push_back(v(1, 32'h30, 1, 4, 1, 0));
    vecs.push_back(v(0, 32'h00, 0, 3, 1, 1));
    vecs.push_back(v(0, 32'h00, 1, 3, 1, 1));
    vecs.push_back(v(0, 32'h00, 1, 2, 1, 1));
    vecs.push_back(v(0, 32'h00, 1, 1, 1, 1));
    vecs.push_back(v(0, 32'h00, 0, 0, 0, 1));

    rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    enq_pc = '0; enq_instr = '0; enq_pcplus4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      cycle(vecs[i].ev, vecs[i].pc, vecs[i].dr, 1'b0, 1'b0, 1'b1,
            vecs[i].exp_cnt, vecs[i].exp_dv, vecs[i].exp_er);
    end

    // Wrap-around stream with decode always ready.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0);
      chk("stream_count_le1", 32'(count <= 3'd1), 32'd1);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush with a pending enq drops everything, then new entry is first out.
    step(1'b1, 32'h34, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h38, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3C, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b1, 1'b1);
    cycle(1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b1);
    chk("flush_first_out_pc", 32'(sb_q.size()), 32'd0);

    // Reset mid-stream behaves like flush.
    step(1'b1, 32'h90, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h94, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h98, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small in-order instruction buffer between the fetch stage and the decode stage of the pipelined core.
- Fetch pushes {instr, PC, PCPlus4} each cycle it has a valid instruction; decode pops one entry per cycle when not stalled.
- Absorbs decode stalls without freezing fetch immediately.
- Discards all buffered entries on a control-flow flush.
- Presents a canonical NOP bubble to decode whenever empty.

Parameters:
- DATA_WIDTH, 32, width of instruction word and PCPlus4.
- ADDRESS_WIDTH, 32, width of PC.
- DEPTH, 4, number of entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  discard all entries (branch/jump taken); synchronous.
- enq_valid  input  1  fetch presents a valid entry.
- enq_ready  output  1  queue can accept an entry this cycle.
- enq_instr  input  DATA_WIDTH  fetched instruction.
- enq_pc  input  ADDRESS_WIDTH  PC of fetched instruction.
- enq_pcplus4  input  DATA_WIDTH  PC+4 of fetched instruction.
- deq_valid  output  1  head entry is valid.
- deq_ready  input  1  decode consumes head this cycle (decode not stalled).
- deq_instr  output  DATA_WIDTH  head instruction, or NOP when empty.
- deq_pc  output  ADDRESS_WIDTH  head PC, or 0 when empty.
- deq_pcplus4  output  DATA_WIDTH  head PC+4, or 0 when empty.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset: rd_ptr = 0, wr_ptr = 0, count = 0.
  - Outputs after reset: deq_valid = 0, deq_instr = 32'h00000013, deq_pc = 0, deq_pcplus4 = 0, enq_ready = 1.
  - Storage contents are don't-care.
- Handshake:
  - enq fires when enq_valid && enq_ready.
  - deq fires when deq_valid && deq_ready.
- Flags (combinational from registered state only; no input-to-output combinational path):
  - enq_ready = (count != DEPTH).
  - deq_valid = (count != 0).
- Show-ahead read: deq_* are driven combinationally from the storage entry at rd_ptr when count != 0.
  - Empty: deq_instr = NOP (addi x0,x0,0 = 32'h00000013), deq_pc = 0, deq_pcplus4 = 0.
- Latency: an entry enqueued in cycle N appears on deq_* with deq_valid = 1 in cycle N+1. There is no same-cycle bypass.
- Pointer update: wr_ptr advances by 1 on enq; rd_ptr advances by 1 on deq. Both wrap modulo DEPTH.
- Count update:
  - +1 on enq only.
  - -1 on deq only.
  - Unchanged when both or neither fire.
- Full (count = DEPTH): enq_ready = 0 and enq_valid is ignored. A deq in the same cycle still fires; enq_ready rises the next cycle.
- Empty (count = 0): deq_ready is ignored. A simultaneous enq makes count = 1 next cycle.
- Flush: next cycle rd_ptr = wr_ptr = 0 and count = 0.
  - Flush takes priority over enq and deq in the same cycle; the entry presented that cycle is dropped.
- rst: same effect as flush. rst has priority over flush.
- Reset or flush mid-stream: no partial entries survive. deq_valid = 0 in the cycle after rst/flush is asserted.
- Storage writes occur only on a fired enq. A held deq_ready = 0 leaves outputs stable.

Decomposition:
- Shared package `core_pkg` holds:
  - NOP_INSTR = 32'h00000013.
  - Struct type `fetch_entry_t` {instr, pc, pcplus4}, used by fetch, fetch_queue and the decode-side pipeline register.
- One sub-module: `fq_mem`, a DEPTH x $bits(fetch_entry_t) register array.
  - One synchronous write port (we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
  - No reset on contents.
- Pointer, count and flag logic stay in fetch_queue.

Test Plan:
1. Reset then idle → deq_valid = 0, deq_instr = 32'h00000013, deq_pc = 0, enq_ready = 1, count = 0.
2. Single pass-through → enq {instr=32'h00500093, pc=0x0, pcplus4=0x4} in cycle 1 with deq_ready = 1. Cycle 2: deq_valid = 1, deq_instr = 32'h00500093, deq_pc = 0x0. Cycle 3: empty, NOP.
3. Fill with decode stalled (deq_ready = 0) → enqueue pc = 0x0, 0x4, 0x8, 0xC. count reaches 4 and enq_ready = 0. A fifth enq (pc = 0x10) is not accepted. Release deq_ready → PCs 0x0, 0x4, 0x8, 0xC emerge in order on consecutive cycles.
4. Full with simultaneous enq and deq → at count = 4 assert deq_ready and enq_valid. Head pops; count = 3 next cycle; the enq is not taken. Following cycle enq_ready = 1.
5. Wrap-around → stream 10 entries pc = 0x0..0x24 with deq_ready = 1 every cycle. Output PC sequence equals input sequence; count stays <= 1.
6. Flush with pending enq → count = 3, assert flush together with enq_valid (pc = 0x40). Next cycle count = 0, deq_valid = 0, deq_instr = NOP. A subsequent enq pc = 0x80 is the first entry out.
